// File: rtl/ycbcr2rgb.sv
// YCbCr 4:4:4 to RGB stream converter: 3-stage fixed-latency arithmetic
// pipeline per lane, followed by an output FIFO with credit-based input flow
// control so the pipeline itself never has to stall.
module ycbcr2rgb #(
    parameter int unsigned pix_per_clock = 1,
    parameter int unsigned data_width    = 8,
    parameter int unsigned fifo_depth    = 8
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [24*pix_per_clock-1:0]   rdata,
    input  logic                          rlast,
    input  logic                          ruser,
    input  logic                          rvalid,
    output logic                          rready,
    output logic [24*pix_per_clock-1:0]   tdata,
    output logic                          tlast,
    output logic                          tuser,
    output logic                          tvalid,
    input  logic                          tready
);

    localparam int unsigned comp_w  = data_width;
    localparam int unsigned lane_w  = 3 * comp_w;
    localparam int unsigned bus_w   = lane_w * pix_per_clock;
    localparam int unsigned entry_w = bus_w + 2;
    localparam int unsigned ptr_w   = $clog2(fifo_depth);
    localparam int unsigned cnt_w   = ptr_w + 1;
    localparam int unsigned math_w  = 18;

    typedef logic signed [math_w-1:0] math_t;

    // Saturate a signed intermediate to the unsigned 0..255 component range
    function automatic logic [comp_w-1:0] clamp8(input math_t v);
        if (v < math_t'(0))
            return '1 & comp_w'(0);
        else if (v > math_t'(255))
            return comp_w'(255);
        else
            return v[comp_w-1:0];
    endfunction

    // Final per-lane add of Y to the scaled chroma offsets, packed as {R,G,B}
    function automatic logic [lane_w-1:0] lane_rgb(input logic [comp_w-1:0] y,
                                                   input math_t ro,
                                                   input math_t go,
                                                   input math_t bo);
        math_t ys;
        ys = $signed(math_w'(y));
        return {clamp8(ys + ro), clamp8(ys - go), clamp8(ys + bo)};
    endfunction

    logic                accept;
    logic [comp_w-1:0]   y_c   [pix_per_clock];
    math_t               d_b_c [pix_per_clock];
    math_t               d_r_c [pix_per_clock];

    logic                s1_v, s1_last, s1_user;
    logic [comp_w-1:0]   s1_y   [pix_per_clock];
    math_t               s1_pr  [pix_per_clock];
    math_t               s1_pgb [pix_per_clock];
    math_t               s1_pgr [pix_per_clock];
    math_t               s1_pb  [pix_per_clock];

    logic                s2_v, s2_last, s2_user;
    logic [comp_w-1:0]   s2_y  [pix_per_clock];
    math_t               s2_ro [pix_per_clock];
    math_t               s2_go [pix_per_clock];
    math_t               s2_bo [pix_per_clock];

    logic                s3_v, s3_last, s3_user;
    logic [bus_w-1:0]    s3_rgb;

    logic [entry_w-1:0]  mem [fifo_depth];
    logic [entry_w-1:0]  head;
    logic [ptr_w-1:0]    wr_ptr, rd_ptr;
    logic [cnt_w-1:0]    count, count_next, inflight_next;
    logic                fifo_wr, fifo_rd;

    // Split each lane into Y and zero-centred chroma differences
    always_comb begin
        accept = rvalid && rready;
        for (int i = 0; i < int'(pix_per_clock); i++) begin
            y_c[i]   = rdata[lane_w*i +: comp_w];
            d_b_c[i] = $signed(math_w'(rdata[lane_w*i + comp_w +: comp_w])) - math_t'(128);
            d_r_c[i] = $signed(math_w'(rdata[lane_w*i + 2*comp_w +: comp_w])) - math_t'(128);
        end
    end

    // S1: register the four chroma products
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_user <= 1'b0;
            for (int i = 0; i < int'(pix_per_clock); i++) begin
                s1_y[i]   <= '0;
                s1_pr[i]  <= '0;
                s1_pgb[i] <= '0;
                s1_pgr[i] <= '0;
                s1_pb[i]  <= '0;
            end
        end else begin
            s1_v    <= accept;
            s1_last <= rlast;
            s1_user <= ruser;
            for (int i = 0; i < int'(pix_per_clock); i++) begin
                s1_y[i]   <= y_c[i];
                s1_pr[i]  <= math_t'(359) * d_r_c[i];
                s1_pgb[i] <= math_t'(88)  * d_b_c[i];
                s1_pgr[i] <= math_t'(183) * d_r_c[i];
                s1_pb[i]  <= math_t'(454) * d_b_c[i];
            end
        end
    end

    // S2: round and floor-shift the products into component offsets
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_user <= 1'b0;
            for (int i = 0; i < int'(pix_per_clock); i++) begin
                s2_y[i]  <= '0;
                s2_ro[i] <= '0;
                s2_go[i] <= '0;
                s2_bo[i] <= '0;
            end
        end else begin
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_user <= s1_user;
            for (int i = 0; i < int'(pix_per_clock); i++) begin
                s2_y[i]  <= s1_y[i];
                s2_ro[i] <= (s1_pr[i] + math_t'(128)) >>> 8;
                s2_go[i] <= (s1_pgb[i] + s1_pgr[i] + math_t'(128)) >>> 8;
                s2_bo[i] <= (s1_pb[i] + math_t'(128)) >>> 8;
            end
        end
    end

    // S3: add Y and saturate each component
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s3_v    <= 1'b0;
            s3_last <= 1'b0;
            s3_user <= 1'b0;
            s3_rgb  <= '0;
        end else begin
            s3_v    <= s2_v;
            s3_last <= s2_last;
            s3_user <= s2_user;
            for (int i = 0; i < int'(pix_per_clock); i++)
                s3_rgb[lane_w*i +: lane_w] <= lane_rgb(s2_y[i], s2_ro[i], s2_go[i], s2_bo[i]);
        end
    end

    // FIFO occupancy and credit bookkeeping for the next cycle
    always_comb begin
        fifo_wr       = s3_v;
        fifo_rd       = tvalid && tready;
        count_next    = count + cnt_w'(fifo_wr) - cnt_w'(fifo_rd);
        inflight_next = cnt_w'(accept) + cnt_w'(s1_v) + cnt_w'(s2_v);
        head          = mem[rd_ptr];
    end

    // Output FIFO storage, pointers, and registered tvalid/rready
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tvalid <= 1'b0;
            rready <= 1'b0;
            for (int i = 0; i < int'(fifo_depth); i++)
                mem[i] <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr] <= {s3_last, s3_user, s3_rgb};
                wr_ptr      <= wr_ptr + ptr_w'(1);
            end
            if (fifo_rd)
                rd_ptr <= rd_ptr + ptr_w'(1);
            count  <= count_next;
            tvalid <= (count_next != '0);
            rready <= (count_next + inflight_next) < cnt_w'(fifo_depth);
        end
    end

    // Head entry drives the output beat; it holds while the consumer stalls
    assign tdata = head[bus_w-1:0];
    assign tuser = head[bus_w];
    assign tlast = head[bus_w+1];

    // Credits must make a write into a full FIFO impossible
    always @(posedge clk_in) begin
        if (!reset)
            assert (!(fifo_wr && !fifo_rd && count == cnt_w'(fifo_depth)))
                else $error("ycbcr2rgb: write into full output FIFO");
    end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed bench for ycbcr2rgb (single lane): reset state, hand-computed
// conversions, latency, backpressure, random-ready streaming, mid-frame reset.
module tb_ycbcr2rgb;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [23:0] rdata;
    logic        rlast, ruser, rvalid, rready;
    logic [23:0] tdata;
    logic        tlast, tuser, tvalid, tready;

    int checks = 0;
    int errors = 0;
    logic [25:0] cap_q [$];

    ycbcr2rgb #(.pix_per_clock(1), .data_width(8), .fifo_depth(8)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .rdata  (rdata),
        .rlast  (rlast),
        .ruser  (ruser),
        .rvalid (rvalid),
        .rready (rready),
        .tdata  (tdata),
        .tlast  (tlast),
        .tuser  (tuser),
        .tvalid (tvalid),
        .tready (tready)
    );

    always #5 clk_in = ~clk_in;

    // Record every beat that will transfer on the coming rising edge
    always @(negedge clk_in) begin
        if (!reset && tvalid && tready)
            cap_q.push_back({tlast, tuser, tdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] grey_in(input logic [7:0] y);
        return {8'd128, 8'd128, y};
    endfunction

    function automatic logic [25:0] cap_at(input int i);
        if (i < cap_q.size())
            return cap_q[i];
        return 'x;
    endfunction

    // Offer one beat until accepted (bounded); called just after a rising edge
    task automatic send(input logic [23:0] d, input logic l, input logic u,
                        input bit rnd, output bit ok);
        bit acc;
        ok     = 1'b0;
        rvalid = 1'b1;
        rdata  = d;
        rlast  = l;
        ruser  = u;
        for (int n = 0; n < 200; n++) begin
            if (rnd) tready = 1'($urandom_range(0, 1));
            @(negedge clk_in);
            acc = rready;
            @(posedge clk_in);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        rvalid = 1'b0;
    endtask

    // Wait (bounded) until n output beats have been captured
    task automatic wait_out(input int n, input bit rnd, input string tag);
        for (int c = 0; c < 1000 && cap_q.size() < n; c++) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk_in);
            #1;
        end
        tready = 1'b1;
        chk(tag, cap_q.size(), n);
    endtask

    logic [23:0] vin  [7];
    logic [23:0] vexp [7];

    initial begin
        bit          ok, all_ok, acc, held_ok, have_head;
        int          k;
        logic [23:0] head;

        // inputs are {Cr,Cb,Y}; expectations are {R,G,B}
        vin[0] = 24'h80_80_80;  vexp[0] = 24'h80_80_80;
        vin[1] = 24'h80_80_00;  vexp[1] = 24'h00_00_00;
        vin[2] = 24'h80_80_FF;  vexp[2] = 24'hFF_FF_FF;
        vin[3] = 24'hFF_55_4C;  vexp[3] = 24'hFE_00_00;  // (76,85,255)
        vin[4] = 24'h80_00_00;  vexp[4] = 24'h00_2C_00;  // B raw -227, G = 44
        vin[5] = 24'hFF_FF_FF;  vexp[5] = 24'hFF_79_FF;  // G = 255-134
        vin[6] = 24'hF0_5A_51;  vexp[6] = 24'hEE_0E_0E;  // (81,90,240)

        reset  = 1'b1;
        rdata  = '0;
        rlast  = 1'b0;
        ruser  = 1'b0;
        rvalid = 1'b0;
        tready = 1'b0;

        // reset state
        #12;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_tdata",  tdata,  0);
        chk("rst_tlast",  tlast,  0);
        chk("rst_tuser",  tuser,  0);
        @(posedge clk_in); #1;
        reset = 1'b0;
        @(posedge clk_in); #1;
        chk("idle_rready", rready, 1);

        // latency: accept at E1, visible after E4, consumed at E5
        tready = 1'b1;
        rvalid = 1'b1; rdata = 24'h80_80_80; rlast = 1'b1; ruser = 1'b1;
        @(posedge clk_in); #1;
        rvalid = 1'b0; rlast = 1'b0; ruser = 1'b0;
        chk("lat_e1_tvalid", tvalid, 0);
        @(posedge clk_in); #1;
        chk("lat_e2_tvalid", tvalid, 0);
        @(posedge clk_in); #1;
        chk("lat_e3_tvalid", tvalid, 0);
        @(posedge clk_in); #1;
        chk("lat_e4_tvalid", tvalid, 1);
        chk("lat_e4_beat", {tlast, tuser, tdata}, {2'b11, 24'h80_80_80});
        @(posedge clk_in); #1;
        chk("lat_e5_tvalid", tvalid, 0);
        cap_q.delete();

        // directed conversion vectors, last/user patterns varied
        all_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(vin[i], 1'(i), 1'(i >> 1), 1'b0, ok);
            all_ok &= ok;
        end
        chk("dir_accept", all_ok, 1);
        wait_out(7, 1'b0, "dir_count");
        for (int i = 0; i < 7; i++)
            chk($sformatf("dir_vec%0d", i), cap_at(i), {1'(i), 1'(i >> 1), vexp[i]});
        cap_q.delete();

        // backpressure: tready low for 30 cycles while 20 beats are offered
        tready = 1'b0; k = 0; held_ok = 1'b1; have_head = 1'b0; head = '0;
        for (int c = 0; c < 30; c++) begin
            rvalid = (k < 20);
            rdata  = grey_in(8'(10 + k));
            rlast  = 1'b0;
            ruser  = 1'b0;
            @(negedge clk_in);
            acc = rvalid && rready;
            if (tvalid) begin
                if (!have_head) begin
                    head = tdata;
                    have_head = 1'b1;
                end else if (tdata !== head) begin
                    held_ok = 1'b0;
                end
            end
            @(posedge clk_in); #1;
            if (acc) k++;
        end
        rvalid = 1'b0;
        chk("bp_accepted", k, 8);
        chk("bp_rready_low", rready, 0);
        chk("bp_tvalid", tvalid, 1);
        chk("bp_head", tdata, 24'h0A_0A_0A);
        chk("bp_held", held_ok, 1);
        chk("bp_no_xfer", cap_q.size(), 0);
        tready = 1'b1;
        all_ok = 1'b1;
        for (int j = k; j < 20; j++) begin
            send(grey_in(8'(10 + j)), 1'b0, 1'b0, 1'b0, ok);
            all_ok &= ok;
        end
        chk("bp_rest_accept", all_ok, 1);
        wait_out(20, 1'b0, "bp_count");
        for (int i = 0; i < 20; i++)
            chk($sformatf("bp_beat%0d", i), cap_at(i), {2'b00, {3{8'(10 + i)}}});
        cap_q.delete();

        // streaming a 16x3 frame with random tready
        all_ok = 1'b1;
        for (int p = 0; p < 48; p++) begin
            send(vin[p % 7], (p % 16) == 15, p == 0, 1'b1, ok);
            all_ok &= ok;
        end
        chk("str_accept", all_ok, 1);
        wait_out(48, 1'b1, "str_count");
        for (int p = 0; p < 48; p++)
            chk($sformatf("str_pix%0d", p), cap_at(p),
                {1'((p % 16) == 15), 1'(p == 0), vexp[p % 7]});
        cap_q.delete();

        // reset mid-frame at pixel 100
        tready = 1'b1;
        for (int p = 0; p < 100; p++)
            send(grey_in(8'(p)), 1'b0, p == 0, 1'b0, ok);
        rvalid = 1'b1; rdata = grey_in(8'd100);
        #2;
        chk("mid_busy_tvalid", tvalid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_beat", {tlast, tuser, tdata}, 0);
        rvalid = 1'b0;
        @(posedge clk_in); @(posedge clk_in); #1;
        reset = 1'b0;
        cap_q.delete();
        @(posedge clk_in); #1;
        all_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(vin[i], i == 6, i == 0, 1'b0, ok);
            all_ok &= ok;
        end
        chk("post_accept", all_ok, 1);
        wait_out(7, 1'b0, "post_count");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_in); #1;
        end
        chk("post_no_stale", cap_q.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("post_vec%0d", i), cap_at(i), {1'(i == 6), 1'(i == 0), vexp[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
